// File: rtl/ps2_kbd_ctrl.sv
// PS/2 Set-2 scancode controller: folds E0/F0/E1 prefixes into 10-bit key events,
// buffers them in a FIFO and exposes DATA/STATUS/CTRL registers plus a level irq.
module ps2_kbd_ctrl #(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset_ni,
  input  logic [7:0]  ps2_code_i,
  input  logic        ps2_strobe_i,
  input  logic        ps2_err_i,
  input  logic        sel_i,
  input  logic        we_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        irq_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK, S_SKIP} state_e;

  state_e          state_q, state_d;
  logic [2:0]      skip_q, skip_d;
  logic [9:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d, err_q, err_d, en_q, en_d, irq_en_q, irq_en_d, irq_q;
  logic [31:0]     rdata_q, rdata_d;

  logic            rd, wr, ne, full, pop, flush, err_set, evt_v, push, ovf_set;
  logic [9:0]      evt;
  logic            unused_wdata;

  assign unused_wdata = ^wdata_i[31:4];

  assign rd      = sel_i & ~we_i;
  assign wr      = sel_i & we_i;
  assign ne      = (count_q != '0);
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign pop     = rd & (addr_i == 2'd0) & ne;
  assign flush   = wr & (addr_i == 2'd2) & wdata_i[2];
  assign err_set = en_q & ps2_err_i;

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    evt_v   = 1'b0;
    evt     = '0;
    if (!en_q || err_set || flush) begin
      state_d = S_IDLE;
    end else if (ps2_strobe_i) begin
      case (state_q)
        S_IDLE: begin
          if (ps2_code_i == 8'hE0)      state_d = S_EXT;
          else if (ps2_code_i == 8'hF0) state_d = S_BRK;
          else if (ps2_code_i == 8'hE1) begin
            state_d = S_SKIP;
            skip_d  = 3'd7;
          end else begin
            evt_v = 1'b1;
            evt   = {2'b00, ps2_code_i};
          end
        end
        S_EXT: begin
          if (ps2_code_i == 8'hF0) state_d = S_EXT_BRK;
          else if (ps2_code_i != 8'hE0) begin
            evt_v   = 1'b1;
            evt     = {2'b01, ps2_code_i};
            state_d = S_IDLE;
          end
        end
        S_BRK: begin
          if (ps2_code_i == 8'hE0) state_d = S_EXT_BRK;
          else if (ps2_code_i != 8'hF0) begin
            evt_v   = 1'b1;
            evt     = {2'b10, ps2_code_i};
            state_d = S_IDLE;
          end
        end
        S_EXT_BRK: begin
          if (ps2_code_i != 8'hE0 && ps2_code_i != 8'hF0) begin
            evt_v   = 1'b1;
            evt     = {2'b11, ps2_code_i};
            state_d = S_IDLE;
          end
        end
        S_SKIP: begin
          // Pause sequence: swallow the 7 trailing bytes, emit one extended E1 event.
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) begin
            evt_v   = 1'b1;
            evt     = {2'b01, 8'hE1};
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // A same-cycle pop frees a slot, so a push into a full FIFO still lands.
  assign push    = evt_v & (~full | pop);
  assign ovf_set = evt_v & full & ~pop;

  always_comb begin
    if (flush) count_d = '0;
    else       count_d = count_q + CW'(push) - CW'(pop);

    ovf_d    = (ovf_q & ~(wr & (addr_i == 2'd1) & wdata_i[2])) | ovf_set;
    err_d    = (err_q & ~(wr & (addr_i == 2'd1) & wdata_i[3])) | err_set;
    en_d     = (wr && addr_i == 2'd2) ? wdata_i[0] : en_q;
    irq_en_d = (wr && addr_i == 2'd2) ? wdata_i[1] : irq_en_q;

    rdata_d = rdata_q;
    if (rd) begin
      case (addr_i)
        2'd0:    rdata_d = ne ? {1'b1, 21'b0, mem[rptr_q]} : '0;
        2'd1:    rdata_d = {16'b0, 8'(count_q), 4'b0, err_q, ovf_q, full, ne};
        2'd2:    rdata_d = {30'b0, irq_en_q, en_q};
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_ni) begin
      state_q  <= S_IDLE;
      skip_q   <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      en_q     <= 1'b1;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      skip_q   <= skip_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
      en_q     <= en_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_en_d & (count_d != '0);
      rdata_q  <= rdata_d;
      if (flush) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (push) wptr_q <= wptr_q + AW'(1);
        if (pop)  rptr_q <= rptr_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_ni && push) mem[wptr_q] <= evt;
  end

  assign rdata_o = rdata_q;
  assign irq_o   = irq_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Scoreboard bench for ps2_kbd_ctrl: a prefix-flag/queue model predicts reads and irq,
// a monitor compares every registered read response against the expected queue.
module tb_ps2_kbd_ctrl;
  localparam int D = 16;

  logic        clk = 1'b0;
  logic        reset_ni = 1'b0;
  logic [7:0]  ps2_code_i = '0;
  logic        ps2_strobe_i = 1'b0, ps2_err_i = 1'b0;
  logic        sel_i = 1'b0, we_i = 1'b0;
  logic [1:0]  addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [31:0] rdata_o;
  logic        irq_o;

  always #5 clk = ~clk;

  ps2_kbd_ctrl #(.FIFO_DEPTH(D)) dut (
    .clk(clk), .reset_ni(reset_ni), .ps2_code_i(ps2_code_i), .ps2_strobe_i(ps2_strobe_i),
    .ps2_err_i(ps2_err_i), .sel_i(sel_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .rdata_o(rdata_o), .irq_o(irq_o)
  );

  int n_chk = 0, n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: event queue, sticky flags, pending prefix flags.
  logic [9:0]  m_q[$];
  bit          m_ovf, m_err, m_en, m_irqen, m_ext, m_brk;
  int          m_skip;
  logic [31:0] exp_q[$];
  bit          rd_seen = 0, irq_on = 0;

  function automatic void m_reset();
    m_q.delete(); m_ovf = 0; m_err = 0; m_en = 1; m_irqen = 0;
    m_ext = 0; m_brk = 0; m_skip = 0;
  endfunction

  function automatic void m_clear_prefix();
    m_ext = 0; m_brk = 0; m_skip = 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return (m_q.size() != 0) ? {1'b1, 21'b0, m_q[0]} : 32'h0;
      2'd1:    return {16'b0, 8'(m_q.size()), 4'b0, m_err, m_ovf,
                       (m_q.size() == D), (m_q.size() != 0)};
      2'd2:    return {30'b0, m_irqen, m_en};
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_decode(input logic [7:0] b, output bit v, output logic [9:0] e);
    v = 0; e = '0;
    if (m_skip > 0) begin
      m_skip--;
      if (m_skip == 0) begin v = 1; e = {2'b01, 8'hE1}; end
    end else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE1 && !m_ext && !m_brk) m_skip = 7;
    else begin
      v = 1; e = {m_brk, m_ext, b};
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic cycle(input bit stb, input logic [7:0] code, input bit er, input bit sel,
                       input bit we, input logic [1:0] a, input logic [31:0] wd);
    bit pre_en, do_pop, do_flush, ev_v;
    logic [9:0] ev;
    ps2_strobe_i = stb; ps2_code_i = code; ps2_err_i = er;
    sel_i = sel; we_i = we; addr_i = a; wdata_i = wd;
    if (sel && !we) exp_q.push_back(m_read(a));
    pre_en   = m_en;
    do_pop   = sel && !we && a == 2'd0 && m_q.size() != 0;
    do_flush = sel && we && a == 2'd2 && wd[2];
    @(posedge clk); #1;
    ps2_strobe_i = 0; ps2_err_i = 0; sel_i = 0; we_i = 0;
    if (sel && we && a == 2'd1) begin
      if (wd[2]) m_ovf = 0;
      if (wd[3]) m_err = 0;
    end
    ev_v = 0; ev = '0;
    if (!pre_en) m_clear_prefix();
    else if (er) begin m_err = 1; m_clear_prefix(); end
    else if (stb) m_decode(code, ev_v, ev);
    if (do_flush) begin
      m_q.delete(); m_clear_prefix();
    end else begin
      if (do_pop) void'(m_q.pop_front());
      if (ev_v) begin
        if (m_q.size() < D) m_q.push_back(ev);
        else m_ovf = 1;
      end
    end
    if (sel && we && a == 2'd2) begin m_en = wd[0]; m_irqen = wd[1]; end
  endtask

  task automatic send(input logic [7:0] b);  cycle(1, b, 0, 0, 0, 0, 0);  endtask
  task automatic rd(input logic [1:0] a);     cycle(0, 0, 0, 1, 0, a, 0);  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d); cycle(0, 0, 0, 1, 1, a, d); endtask
  task automatic idle();                      cycle(0, 0, 0, 0, 0, 0, 0);  endtask

  task automatic do_reset(input logic [7:0] code);
    reset_ni = 0; ps2_strobe_i = 1; ps2_code_i = code;
    @(posedge clk); #1;
    reset_ni = 1; ps2_strobe_i = 0;
    m_reset(); exp_q.delete();
    check("reset_rdata", rdata_o, 32'h0);
    check("reset_irq", 32'(irq_o), 32'h0);
  endtask

  always @(posedge clk) rd_seen <= reset_ni && sel_i && !we_i;

  always @(negedge clk) begin
    if (rd_seen) begin
      if (exp_q.size() == 0) check("unexpected_read", rdata_o, 32'hDEAD_BEEF);
      else check("rdata", rdata_o, exp_q.pop_front());
    end
    if (irq_on) check("irq", 32'(irq_o), 32'(m_irqen && m_q.size() != 0));
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] c;
    logic [1:0] a;
    logic [31:0] wd;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset(8'h00);
    irq_on = 1;
    rd(1); rd(2);

    send(8'h1C); send(8'hE0); send(8'h74); send(8'hF0); send(8'h1C);
    send(8'hE0); send(8'hF0); send(8'h74);
    repeat (5) rd(0);

    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1); send(8'hF0); send(8'h14); send(8'hF0);
    rd(1);
    send(8'h77);
    rd(1); rd(0); rd(0);

    for (int i = 0; i < 17; i++) send(8'(8'h10 + i));
    rd(1); wr(1, 32'h4); rd(1);
    repeat (17) rd(0);

    send(8'hE0); cycle(0, 0, 1, 0, 0, 0, 0); send(8'h1C);
    rd(1); wr(1, 32'h8); rd(1); rd(0);

    wr(2, 32'h3); send(8'h2A); idle(); rd(0); idle();

    for (int i = 0; i < D; i++) send(8'(8'h40 + i));
    cycle(1, 8'h33, 0, 1, 0, 0, 0);
    rd(1); wr(2, 32'h5); rd(1);

    send(8'hE0); cycle(1, 8'h44, 0, 1, 1, 2, 32'h5); rd(1);
    cycle(1, 8'h55, 0, 1, 0, 0, 0); rd(0);
    wr(2, 32'h0); send(8'h1C); cycle(0, 0, 1, 0, 0, 0, 0); rd(1); wr(2, 32'h1);
    cycle(0, 0, 1, 1, 1, 1, 32'h8); rd(1); wr(1, 32'hC);

    send(8'hE0); send(8'hF0);
    do_reset(8'h74);
    rd(1); rd(2);
    send(8'h74); rd(0);

    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    c = 8'hE0;
        2, 3:    c = 8'hF0;
        4:       c = 8'hE1;
        default: c = 8'($urandom);
      endcase
      a  = 2'($urandom_range(0, 3));
      wd = $urandom;
      if (a == 2'd2) begin
        wd[0] = ($urandom_range(0, 7) != 0);
        wd[2] = ($urandom_range(0, 7) == 0);
      end
      cycle($urandom_range(0, 99) < 60, c, $urandom_range(0, 39) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
            ($urandom_range(0, 1) == 0) ? 2'd0 : a, wd);
    end

    wr(2, 32'h1);
    for (int i = 0; i < D + 2; i++) rd(0);
    rd(1);
    idle(); idle();
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
